// File: rtl/reg_wr_pkg.sv
// Shared types and constants for the two-requester register write arbiter.
package reg_wr_pkg;

   localparam int unsigned DW_DEF = 8;
   localparam int unsigned AW_DEF = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [1:0] ADDR_INV = 2'd0;
   localparam logic [1:0] ADDR_R1  = 2'd1;
   localparam logic [1:0] ADDR_R2  = 2'd2;
   localparam logic [1:0] ADDR_R3  = 2'd3;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; owns the last-grant history bit.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       en,
   output logic [1:0] gnt,
   output logic       gnt_idx
);

   logic last_grant_q;

   // Lone requester wins outright; on contention the one not served last time wins.
   always_comb begin
      gnt     = 2'b00;
      gnt_idx = 1'b0;
      case (req)
         2'b01: begin
            gnt     = 2'b01;
            gnt_idx = 1'b0;
         end
         2'b10: begin
            gnt     = 2'b10;
            gnt_idx = 1'b1;
         end
         2'b11: begin
            if (last_grant_q) begin
               gnt     = 2'b01;
               gnt_idx = 1'b0;
            end else begin
               gnt     = 2'b10;
               gnt_idx = 1'b1;
            end
         end
         default: begin
            gnt     = 2'b00;
            gnt_idx = 1'b0;
         end
      endcase
   end

   // History starts at 1 so requester 0 wins the first contended grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_q <= 1'b1;
      end else if (en && (req != 2'b00)) begin
         last_grant_q <= gnt_idx;
      end
   end

endmodule

// File: rtl/reg_wr_arbiter.sv
// Two-requester write controller: arbitrates, decodes chip select and sequences
// setup / write strobe / acknowledge towards a 3-register write block.
module reg_wr_arbiter
   import reg_wr_pkg::*;
#(
   parameter int unsigned DW = DW_DEF,
   parameter int unsigned AW = AW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] data0,
   input  logic          req1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] data1,
   output logic          ack0,
   output logic          ack1,
   output logic          err,
   output logic          my_wr,
   output logic          CS_reg1,
   output logic          CS_reg2,
   output logic          CS_reg3,
   output logic [DW-1:0] data_out,
   output logic          busy
);

   state_t        state_q, state_d;
   logic [AW-1:0] lat_addr_q, lat_addr_d;
   logic [DW-1:0] lat_data_q, lat_data_d;
   logic          lat_idx_q, lat_idx_d;
   logic          err_flag_q, err_flag_d;

   logic          ack0_q, ack0_d;
   logic          ack1_q, ack1_d;
   logic          err_q, err_d;
   logic          my_wr_q, my_wr_d;
   logic [2:0]    cs_q, cs_d;
   logic [DW-1:0] data_out_q, data_out_d;
   logic          busy_q, busy_d;

   logic [1:0]    gnt;
   logic          gnt_idx;
   logic          arb_en;
   logic [2:0]    cs_dec;

   rr_arb2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     ({req1, req0}),
      .en      (arb_en),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   // One-hot chip select from the latched address; the invalid address selects nothing.
   always_comb begin
      cs_dec = 3'b000;
      if (lat_addr_q == AW'(ADDR_R1)) cs_dec = 3'b001;
      if (lat_addr_q == AW'(ADDR_R2)) cs_dec = 3'b010;
      if (lat_addr_q == AW'(ADDR_R3)) cs_dec = 3'b100;
   end

   // Next state and next registered outputs; outputs reflect the state just left.
   always_comb begin
      state_d    = state_q;
      lat_addr_d = lat_addr_q;
      lat_data_d = lat_data_q;
      lat_idx_d  = lat_idx_q;
      err_flag_d = err_flag_q;
      ack0_d     = 1'b0;
      ack1_d     = 1'b0;
      err_d      = 1'b0;
      my_wr_d    = 1'b0;
      cs_d       = 3'b000;
      data_out_d = data_out_q;
      arb_en     = 1'b0;
      unique case (state_q)
         IDLE: begin
            arb_en = 1'b1;
            if (gnt != 2'b00) begin
               lat_idx_d  = gnt_idx;
               lat_addr_d = gnt_idx ? addr1 : addr0;
               lat_data_d = gnt_idx ? data1 : data0;
               err_flag_d = 1'b0;
               state_d    = SETUP;
            end
         end
         SETUP: begin
            data_out_d = lat_data_q;
            cs_d       = cs_dec;
            if (lat_addr_q == AW'(ADDR_INV)) begin
               err_flag_d = 1'b1;
               state_d    = DONE;
            end else begin
               state_d    = WRITE;
            end
         end
         WRITE: begin
            my_wr_d = 1'b1;
            cs_d    = cs_q;
            state_d = DONE;
         end
         DONE: begin
            ack0_d  = ~lat_idx_q;
            ack1_d  = lat_idx_q;
            err_d   = err_flag_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   // State, latches and output registers; reset aborts any transfer in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         lat_addr_q <= '0;
         lat_data_q <= '0;
         lat_idx_q  <= 1'b0;
         err_flag_q <= 1'b0;
         ack0_q     <= 1'b0;
         ack1_q     <= 1'b0;
         err_q      <= 1'b0;
         my_wr_q    <= 1'b0;
         cs_q       <= 3'b000;
         data_out_q <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         lat_addr_q <= lat_addr_d;
         lat_data_q <= lat_data_d;
         lat_idx_q  <= lat_idx_d;
         err_flag_q <= err_flag_d;
         ack0_q     <= ack0_d;
         ack1_q     <= ack1_d;
         err_q      <= err_d;
         my_wr_q    <= my_wr_d;
         cs_q       <= cs_d;
         data_out_q <= data_out_d;
         busy_q     <= busy_d;
      end
   end

   assign ack0     = ack0_q;
   assign ack1     = ack1_q;
   assign err      = err_q;
   assign my_wr    = my_wr_q;
   assign CS_reg1  = cs_q[0];
   assign CS_reg2  = cs_q[1];
   assign CS_reg3  = cs_q[2];
   assign data_out = data_out_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Bench for reg_wr_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_reg_wr_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req0 = 1'b0, req1 = 1'b0;
   logic [1:0] addr0 = '0, addr1 = '0;
   logic [7:0] data0 = '0, data1 = '0;
   logic       ack0, ack1, err, my_wr, CS_reg1, CS_reg2, CS_reg3, busy;
   logic [7:0] data_out;

   int tests = 0;
   int fails = 0;

   reg_wr_arbiter #(.DW(8), .AW(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .req0     (req0),
      .addr0    (addr0),
      .data0    (data0),
      .req1     (req1),
      .addr1    (addr1),
      .data1    (data1),
      .ack0     (ack0),
      .ack1     (ack1),
      .err      (err),
      .my_wr    (my_wr),
      .CS_reg1  (CS_reg1),
      .CS_reg2  (CS_reg2),
      .CS_reg3  (CS_reg3),
      .data_out (data_out),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   // Register block stand-in: written on my_wr with the selected chip select.
   logic [7:0] r1 = '0, r2 = '0, r3 = '0;
   initial forever begin
      @(posedge clk);
      if (my_wr) begin
         if (CS_reg1) r1 = data_out;
         if (CS_reg2) r2 = data_out;
         if (CS_reg3) r3 = data_out;
      end
   end

   // ---------------- transaction-level reference model ----------------
   typedef struct packed {
      logic [2:0] cs;
      logic       wr;
      logic       a0;
      logic       a1;
      logic       er;
      logic       bsy;
      logic [7:0] dout;
   } ev_t;

   ev_t  sched[int];
   ev_t  exp_now = '0;
   logic [7:0] exp_dout = '0;
   int   cyc = 0;
   int   t_free = 0;
   bit   m_last = 1'b1;
   bit   mvalid = 1'b0;

   // Each grant books the whole expected output timeline for the following edges.
   initial forever begin
      ev_t ev;
      bit w;
      logic [1:0] a;
      logic [7:0] d;
      @(posedge clk);
      cyc++;
      if (rst) begin
         sched.delete();
         exp_now  = '0;
         exp_dout = '0;
         m_last   = 1'b1;
         t_free   = 0;
         mvalid   = 1'b1;
      end else begin
         if (sched.exists(cyc)) begin
            exp_now = sched[cyc];
            sched.delete(cyc);
         end else begin
            exp_now = '0;
            exp_now.dout = exp_dout;
         end
         exp_dout = exp_now.dout;
         if (cyc >= t_free && (req0 || req1)) begin
            w = (req0 && req1) ? ~m_last : req1;
            m_last = w;
            a = w ? addr1 : addr0;
            d = w ? data1 : data0;
            exp_now.bsy = 1'b1;
            ev = '0;
            ev.dout = d;
            ev.bsy  = 1'b1;
            ev.cs   = (a == 2'd0) ? 3'b000 : (3'b001 << (a - 2'd1));
            sched[cyc + 1] = ev;
            if (a != 2'd0) begin
               ev.wr = 1'b1;
               sched[cyc + 2] = ev;
               ev = '0;
               ev.dout = d;
               ev.a0 = ~w;
               ev.a1 = w;
               sched[cyc + 3] = ev;
               t_free = cyc + 4;
            end else begin
               ev = '0;
               ev.dout = d;
               ev.a0 = ~w;
               ev.a1 = w;
               ev.er = 1'b1;
               sched[cyc + 2] = ev;
               t_free = cyc + 3;
            end
         end
      end
   end

   // Every-cycle comparison of all outputs against the model.
   initial forever begin
      ev_t got;
      @(negedge clk);
      if (mvalid) begin
         got = {CS_reg3, CS_reg2, CS_reg1, my_wr, ack0, ack1, err, busy, data_out};
         tests++;
         if (got !== exp_now) begin
            fails++;
            $display("FAIL outputs cyc %0d: got cs=%b wr=%b a0=%b a1=%b err=%b busy=%b dout=%h, expected cs=%b wr=%b a0=%b a1=%b err=%b busy=%b dout=%h",
                     cyc, got.cs, got.wr, got.a0, got.a1, got.er, got.bsy, got.dout,
                     exp_now.cs, exp_now.wr, exp_now.a0, exp_now.a1, exp_now.er,
                     exp_now.bsy, exp_now.dout);
         end
      end
   end

   // ---------------- directed helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic do_reset();
      rst  = 1'b1;
      req0 = 1'b0;
      req1 = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   function automatic logic [2:0] cs_now();
      return {CS_reg3, CS_reg2, CS_reg1};
   endfunction

   initial begin
      int t0, t1, n, t;
      logic [3:0] ord;
      bit saw_wr, saw_cs;
      logic [7:0] s1, s2, s3;

      // Reset state, then a single write to register 2.
      do_reset();
      chk("rst_busy", busy, 0);
      chk("rst_outs", {ack0, ack1, err, my_wr, cs_now()}, 0);
      chk("rst_dout", data_out, 0);
      req0 = 1'b1; addr0 = 2'd2; data0 = 8'hA5;
      tick();
      chk("t1_grant_busy", busy, 1);
      tick();
      chk("t1_setup_cs", cs_now(), 3'b010);
      chk("t1_setup_dout", data_out, 8'hA5);
      chk("t1_setup_wr", my_wr, 0);
      tick();
      chk("t1_write_wr", my_wr, 1);
      tick();
      chk("t1_ack", {ack0, ack1, err}, 3'b100);
      req0 = 1'b0;
      chk("t1_reg2", r2, 8'hA5);
      tick();
      chk("t1_idle_busy", busy, 0);

      // Contention from reset: requester 0 first, acks 4 cycles apart.
      do_reset();
      req0 = 1'b1; addr0 = 2'd1; data0 = 8'h11;
      req1 = 1'b1; addr1 = 2'd3; data1 = 8'h33;
      t0 = -1; t1 = -1;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (ack0 && t0 < 0) begin t0 = i; req0 = 1'b0; end
         if (ack1 && t1 < 0) begin t1 = i; req1 = 1'b0; end
      end
      chk("t2_ack0_time", t0, 3);
      chk("t2_ack1_time", t1, 7);
      chk("t2_reg1", r1, 8'h11);
      chk("t2_reg3", r3, 8'h33);

      // Both held continuously: grants alternate 0,1,0,1.
      do_reset();
      req0 = 1'b1; addr0 = 2'd1; data0 = 8'h21;
      req1 = 1'b1; addr1 = 2'd2; data1 = 8'h42;
      n = 0; ord = '0;
      for (int i = 0; i < 40 && n < 4; i++) begin
         tick();
         if (ack0) begin ord[n] = 1'b0; n++; end
         else if (ack1) begin ord[n] = 1'b1; n++; end
      end
      req0 = 1'b0; req1 = 1'b0;
      chk("t3_count", n, 4);
      chk("t3_order", ord, 4'b1010);
      repeat (3) tick();

      // Invalid address: no strobe, no select, error ack, registers untouched.
      s1 = r1; s2 = r2; s3 = r3;
      req1 = 1'b1; addr1 = 2'd0; data1 = 8'hFF;
      saw_wr = 1'b0; saw_cs = 1'b0; t = -1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (my_wr) saw_wr = 1'b1;
         if (cs_now() != 3'b000) saw_cs = 1'b1;
         if (ack1 && t < 0) begin
            t = i;
            chk("t4_err", err, 1);
            req1 = 1'b0;
         end
      end
      chk("t4_ack_time", t, 2);
      chk("t4_no_wr", saw_wr, 0);
      chk("t4_no_cs", saw_cs, 0);
      chk("t4_regs", {r1, r2, r3}, {s1, s2, s3});

      // Reset during WRITE aborts; the held request is then re-run.
      do_reset();
      s3 = r3;
      req0 = 1'b1; addr0 = 2'd3; data0 = 8'h77;
      tick();
      tick();
      chk("t5_setup_cs", cs_now(), 3'b100);
      rst = 1'b1;
      tick();
      chk("t5_abort_outs", {ack0, ack1, err, my_wr, cs_now(), busy}, 0);
      chk("t5_abort_dout", data_out, 0);
      chk("t5_abort_reg3", r3, s3);
      rst = 1'b0;
      t = -1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (ack0 && t < 0) begin t = i; req0 = 1'b0; end
      end
      chk("t5_rerun_ack", t, 3);
      chk("t5_rerun_reg3", r3, 8'h77);

      // Data changed after grant is ignored.
      do_reset();
      req0 = 1'b1; addr0 = 2'd1; data0 = 8'h5A;
      tick();
      data0 = 8'hC3;
      tick();
      chk("t6_dout", data_out, 8'h5A);
      t = -1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (ack0 && t < 0) begin t = i; req0 = 1'b0; end
      end
      chk("t6_ack", t, 1);
      chk("t6_reg1", r1, 8'h5A);
      chk("t6_hold_dout", data_out, 8'h5A);

      // Randomized traffic, withdrawals, late data changes and occasional resets.
      for (int c = 0; c < 3000; c++) begin
         tick();
         rst = ($urandom_range(199) == 0);
         if (ack0) req0 = ($urandom_range(9) == 0);
         else if (!req0 && $urandom_range(3) == 0) begin
            req0 = 1'b1; addr0 = 2'($urandom); data0 = 8'($urandom);
         end else if (req0 && $urandom_range(15) == 0) req0 = 1'b0;
         if ($urandom_range(7) == 0) data0 = 8'($urandom);
         if (ack1) req1 = ($urandom_range(9) == 0);
         else if (!req1 && $urandom_range(3) == 0) begin
            req1 = 1'b1; addr1 = 2'($urandom); data1 = 8'($urandom);
         end else if (req1 && $urandom_range(15) == 0) req1 = 1'b0;
         if ($urandom_range(7) == 0) addr1 = 2'($urandom);
      end
      rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
      repeat (8) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
